// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display scanner for a CPU PC / ALU result value.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_display,
  input  logic [31:0] alu_result,
  input  logic        sel,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int CW = 24;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          snap_sel;

  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick = (div_cnt == DIV_LAST);

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler: one tick every CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Digit index advances after its slot has been driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 3'd0;
    end else if (tick) begin
      idx <= idx + 3'd1;
    end
  end

  // Snapshot reloads on the digit-7 tick so a frame never mixes two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= 32'h0000_0000;
      snap_sel <= 1'b0;
    end else if (tick && (idx == 3'd7)) begin
      snap     <= sel ? alu_result : pc_display;
      snap_sel <= sel;
    end
  end

  assign nib = snap[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is leading-zero when it and every higher nibble are zero.
  assign blank = (idx != 3'd0) && ((snap >> {idx, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_next  = ~(8'b0000_0001 << idx);
    seg_next = hex_seg(nib);
    dp_next  = !((idx == 3'd7) && snap_sel);
    if (blank) begin
      an_next  = 8'hFF;
      seg_next = 7'h7F;
    end
  end

  // Registered outputs change only on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= 8'hFF;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else if (tick) begin
      an_n  <= an_next;
      seg_n <= seg_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CLK_DIV = 4: frame-table checks plus
// hand sequences for mid-frame source switch, async reset and slot period.
module tb_seg7_scan;

  localparam int N = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_display = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        sel = 1'b0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  int checks = 0;
  int failures = 0;

  seg7_scan #(.CLK_DIV(N)) dut (
    .clk(clk), .rst_n(rst_n), .pc_display(pc_display), .alu_result(alu_result),
    .sel(sel), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [55:0] seg_pk;   // {d7,...,d0}
    logic        dp7;      // expected dp_n in the digit-7 slot
    int          blank_from;
  } vec_t;

  localparam int NV = 4;
  vec_t vecs [NV];
  vec_t rst_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_slot();
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input int d, input vec_t v, input string tag);
    logic       blk;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    blk   = BLANK_EN && (d >= v.blank_from);
    e_an  = blk ? 8'hFF : ~(8'b0000_0001 << d);
    e_seg = blk ? 7'h7F : v.seg_pk[d*7 +: 7];
    e_dp  = (d == 7) ? v.dp7 : 1'b1;
    chk($sformatf("%s_d%0d_an", tag, d), {24'h0, an_n}, {24'h0, e_an});
    chk($sformatf("%s_d%0d_seg", tag, d), {25'h0, seg_n}, {25'h0, e_seg});
    chk($sformatf("%s_d%0d_dp", tag, d), {31'h0, dp_n}, {31'h0, e_dp});
  endtask

  // Slot-period monitor: posedges between an_n changes.
  logic       mon_en = 1'b0;
  int         edges = 0;
  logic [7:0] last_an = 8'hFF;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      edges++;
      if (an_n != last_an) begin
        checks++;
        if (BLANK_EN ? (edges % N != 0) : (edges != N)) begin
          failures++;
          $display("FAIL slot_period actual=%0d expected=%0d", edges, N);
        end
        edges = 0;
      end
      last_an = an_n;
    end
  end

  initial begin
    vec_t p;
    rst_frame = '{1'b0, 32'h0, 32'h0,
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1, 1};
    vecs[0] = '{1'b0, 32'h0040_0000, 32'h1234_5678,
                {7'h40, 7'h40, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1, 6};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h89AB_CDEF,
                {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 1'b0, 8};
    vecs[2] = '{1'b0, 32'h7654_3210, 32'hDEAD_BEEF,
                {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 1'b1, 8};
    vecs[3] = '{1'b0, 32'h0000_00A3, 32'h0000_0000,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h30}, 1'b1, 2};

    // Reset held: outputs idle every cycle.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", c), {15'h0, an_n, seg_n, dp_n}, {15'h0, 8'hFF, 7'h7F, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Frame f checks vecs[f-1] while inputs for the next load are applied.
    for (int f = 0; f <= NV; f++) begin
      if (f < NV) begin
        sel = vecs[f].sel; pc_display = vecs[f].pc; alu_result = vecs[f].alu;
      end else begin
        sel = 1'b0; pc_display = 32'h1357_2468; alu_result = 32'hFFFF_FFFF;
      end
      for (int d = 0; d < 8; d++) begin
        wait_slot();
        check_slot(d, (f == 0) ? rst_frame : vecs[f-1], $sformatf("frame%0d", f));
      end
    end

    // Switch source while digit 3 is shown: rest of frame keeps the PC value.
    p = '{1'b0, 32'h1357_2468, 32'h0,
          {7'h79, 7'h30, 7'h12, 7'h78, 7'h24, 7'h19, 7'h02, 7'h00}, 1'b1, 8};
    for (int d = 0; d < 8; d++) begin
      wait_slot();
      check_slot(d, p, "switch");
      if (d == 3) begin
        sel = 1'b1;
        pc_display = 32'h0;
      end
    end
    p = '{1'b1, 32'h0, 32'hFFFF_FFFF,
          {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 1'b0, 8};
    for (int d = 0; d < 8; d++) begin
      wait_slot();
      check_slot(d, p, "allf");
    end

    // Asynchronous reset between edges in the middle of a frame.
    repeat (9) @(posedge clk);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {15'h0, an_n, seg_n, dp_n}, {15'h0, 8'hFF, 7'h7F, 1'b1});
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; pc_display = 32'hABCD_0123;
    rst_n = 1'b1;
    edges = 0; last_an = 8'hFF; mon_en = 1'b1;
    repeat (N-1) @(posedge clk);
    #1;
    chk("pre_first_tick_an", {24'h0, an_n}, 32'h0000_00FF);
    @(posedge clk);
    #1;
    check_slot(0, rst_frame, "post_rst");
    for (int d = 1; d < 8; d++) begin
      wait_slot();
      check_slot(d, rst_frame, "post_rst");
    end
    // Wrap into the next frame to cover the 7 -> 0 slot period.
    wait_slot();
    chk("after_rst_load_an", {24'h0, an_n}, 32'h0000_00FE);
    chk("after_rst_load_seg", {25'h0, seg_n}, 32'h0000_0030);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
